// File: rtl/melody_sequencer.sv
// Key-pattern recorder/player: samples `keys` once per TICK_DIV cycles into a small
// melody memory and replays it on note_out. Define MELODY_SEQ_TRIM_EN to drop leading silence.
module melody_sequencer #(
    parameter int KEYS     = 8,
    parameter int DEPTH    = 80,
    parameter int TICK_DIV = 100
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [KEYS-1:0]            keys,
    input  logic                       rec_start,
    input  logic                       rec_stop,
    input  logic                       play_start,
    input  logic                       play_stop,
    input  logic                       clear,
    input  logic                       loop,
    output logic [KEYS-1:0]            note_out,
    output logic [1:0]                 state,
    output logic [$clog2(DEPTH+1)-1:0] length,
    output logic                       full,
    output logic                       done
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REC  = 2'b01,
        PLAY = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [IW-1:0]   idx_q, idx_d, idx_next;
    logic [LW-1:0]   length_q, length_d;
    logic [KEYS-1:0] note_q, note_d;
    logic            done_q, done_d;
    logic            mem_we;
    logic            tick_wrap, last_idx, store_sample, stop_hit, stop_any;

    logic [KEYS-1:0] mem [DEPTH];

    assign tick_wrap = (tick_q == TW'(TICK_DIV - 1));
    assign idx_next  = idx_q + IW'(1);
    assign last_idx  = (LW'(idx_q) == length_q - LW'(1));
    assign stop_any  = rec_stop | play_stop;
    assign stop_hit  = (rec_stop && state_q == REC) || (play_stop && state_q == PLAY);

`ifdef MELODY_SEQ_TRIM_EN
    // Silent samples are only dropped until the first audible one has been stored.
    assign store_sample = (length_q != '0) || (keys != '0);
`else
    assign store_sample = 1'b1;
`endif

    assign note_out = note_q;
    assign state    = state_q;
    assign length   = length_q;
    assign full     = (length_q == LW'(DEPTH));
    assign done     = done_q;

    // Memory has no reset; length==0 is what makes old contents unreachable.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[IW'(length_q)] <= keys;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            idx_q    <= '0;
            length_q <= '0;
            note_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            idx_q    <= idx_d;
            length_q <= length_d;
            note_q   <= note_d;
            done_q   <= done_d;
        end
    end

    // A stop pulse outranks start commands even when it has no effect in the current state.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        idx_d    = idx_q;
        length_d = length_q;
        note_d   = note_q;
        done_d   = 1'b0;
        mem_we   = 1'b0;
        if (clear) begin
            state_d  = IDLE;
            tick_d   = '0;
            idx_d    = '0;
            length_d = '0;
            note_d   = '0;
        end else if (stop_hit) begin
            state_d = IDLE;
            tick_d  = '0;
            idx_d   = '0;
            note_d  = '0;
        end else if (rec_start && !stop_any) begin
            state_d  = REC;
            tick_d   = '0;
            idx_d    = '0;
            length_d = '0;
            note_d   = '0;
        end else if (play_start && !stop_any && state_q == IDLE && length_q != '0) begin
            state_d = PLAY;
            tick_d  = '0;
            idx_d   = '0;
            note_d  = mem[0];
        end else begin
            case (state_q)
                REC: begin
                    if (tick_wrap) begin
                        tick_d = '0;
                        if (store_sample) begin
                            mem_we   = 1'b1;
                            length_d = length_q + LW'(1);
                            if (length_q == LW'(DEPTH - 1)) begin
                                state_d = IDLE;
                            end
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                PLAY: begin
                    if (tick_wrap) begin
                        tick_d = '0;
                        if (last_idx) begin
                            idx_d = '0;
                            if (loop) begin
                                note_d = mem[0];
                            end else begin
                                note_d  = '0;
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        end else begin
                            idx_d  = idx_next;
                            note_d = mem[idx_next];
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
